homography_query_scheduler: RTL and testbench

//  Shares one homography lookup unit between two pixel-query requesters (req0, req1).

---
 rtl/homography_query_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_homography_query_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/homography_query_scheduler.sv
// Round-robin scheduler sharing one homography lookup unit between two requesters,
// with an in-order tag FIFO and a flush/drain handshake. Optional counters: HQS_STATS_EN.
module homography_query_scheduler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_25,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [9:0]       req0_x,
    input  logic [9:0]       req0_y,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [9:0]       req1_x,
    input  logic [9:0]       req1_y,
    output logic             req1_ready,
    input  logic             flush,
    output logic             flush_done,
    output logic [9:0]       query_x,
    output logic [9:0]       query_y,
    output logic             start,
    input  logic             ready,
    input  logic [9:0]       return_x,
    input  logic [9:0]       return_y,
    input  logic [4:0]       r,
    input  logic [5:0]       g,
    input  logic [4:0]       b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [9:0]       rsp_x,
    output logic [9:0]       rsp_y,
    output logic [4:0]       rsp_r,
    output logic [5:0]       rsp_g,
    output logic [4:0]       rsp_b,
    output logic             rsp_mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] outstanding
`ifdef HQS_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
    output logic [15:0]      mismatch_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

    typedef struct packed {
        logic       owner;
        logic [9:0] x;
        logic [9:0] y;
    } tag_t;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    tag_t              fifo_q [DEPTH];
    tag_t              head;
    logic              can_grant, gnt0, gnt1, push, pop, spurious, mismatch;
    tag_t              push_tag;

    logic              start_q, flush_done_q, err_q;
    logic [9:0]        query_x_q, query_y_q;
    logic              rsp0_q, rsp1_q, rsp_mm_q;
    logic [9:0]        rsp_x_q, rsp_y_q;
    logic [4:0]        rsp_r_q, rsp_b_q;
    logic [5:0]        rsp_g_q;

    // Arbitration: rr_q set means requester 1 has priority on a tie.
    always_comb begin
        can_grant = (state_q == ST_RUN) && (outstanding_q < CNT_W'(DEPTH));
        gnt0      = can_grant && req0_valid && (!req1_valid || !rr_q);
        gnt1      = can_grant && req1_valid && !gnt0;
        push      = gnt0 || gnt1;
        pop       = ready && (outstanding_q != '0);
        spurious  = ready && (outstanding_q == '0);
        head      = fifo_q[rd_ptr_q];
        mismatch  = (return_x != head.x) || (return_y != head.y);
        push_tag  = gnt1 ? tag_t'{1'b1, req1_x, req1_y} : tag_t'{1'b0, req0_x, req0_y};
        rr_d      = rr_q;
        if (gnt0)      rr_d = 1'b1;
        else if (gnt1) rr_d = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (outstanding_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            rr_q          <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            flush_done_q  <= 1'b0;
            start_q       <= 1'b0;
            query_x_q     <= '0;
            query_y_q     <= '0;
            rsp0_q        <= 1'b0;
            rsp1_q        <= 1'b0;
            rsp_mm_q      <= 1'b0;
            rsp_x_q       <= '0;
            rsp_y_q       <= '0;
            rsp_r_q       <= '0;
            rsp_g_q       <= '0;
            rsp_b_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            outstanding_q <= outstanding_d;
            flush_done_q  <= (state_d == ST_DONE);
            start_q       <= push;
            rsp0_q        <= pop && !head.owner;
            rsp1_q        <= pop && head.owner;
            rsp_mm_q      <= pop && mismatch;
            err_q         <= err_q || spurious || (pop && mismatch);
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                query_x_q <= push_tag.x;
                query_y_q <= push_tag.y;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                rsp_x_q  <= head.x;
                rsp_y_q  <= head.y;
                rsp_r_q  <= r;
                rsp_g_q  <= g;
                rsp_b_q  <= b;
            end
        end
    end

    // Tag storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_25) begin
        if (push) fifo_q[wr_ptr_q] <= push_tag;
    end

`ifdef HQS_STATS_EN
    logic [15:0] gc0_q, gc1_q, mmc_q;

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            gc0_q <= '0;
            gc1_q <= '0;
            mmc_q <= '0;
        end else begin
            if (gnt0 && gc0_q != 16'hFFFF) gc0_q <= gc0_q + 16'd1;
            if (gnt1 && gc1_q != 16'hFFFF) gc1_q <= gc1_q + 16'd1;
            if (pop && mismatch && mmc_q != 16'hFFFF) mmc_q <= mmc_q + 16'd1;
        end
    end

    assign grant_cnt0   = gc0_q;
    assign grant_cnt1   = gc1_q;
    assign mismatch_cnt = mmc_q;
`endif

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign flush_done   = flush_done_q;
    assign query_x      = query_x_q;
    assign query_y      = query_y_q;
    assign start        = start_q;
    assign rsp0_valid   = rsp0_q;
    assign rsp1_valid   = rsp1_q;
    assign rsp_x        = rsp_x_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_r        = rsp_r_q;
    assign rsp_g        = rsp_g_q;
    assign rsp_b        = rsp_b_q;
    assign rsp_mismatch = rsp_mm_q;
    assign err_sticky   = err_q;
    assign outstanding  = outstanding_q;

endmodule

// File: tb/tb_homography_query_scheduler.sv
// Self-checking bench for homography_query_scheduler against a queue-based reference model.
module tb_homography_query_scheduler;

    localparam int DEPTH = 8;

    logic       clk_25 = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 0, req1_valid = 0, flush = 0, ready = 0;
    logic [9:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0, return_x = 0, return_y = 0;
    logic [4:0] r = 0, b = 0;
    logic [5:0] g = 0;
    logic       req0_ready, req1_ready, flush_done, start, rsp0_valid, rsp1_valid;
    logic       rsp_mismatch, err_sticky;
    logic [9:0] query_x, query_y, rsp_x, rsp_y;
    logic [4:0] rsp_r, rsp_b;
    logic [5:0] rsp_g;
    logic [3:0] outstanding;
`ifdef HQS_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, mismatch_cnt;
`endif

    homography_query_scheduler #(.DEPTH(8), .CNT_W(4)) dut (
        .clk_25(clk_25), .rst(rst),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
        .flush(flush), .flush_done(flush_done),
        .query_x(query_x), .query_y(query_y), .start(start),
        .ready(ready), .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .rsp_r(rsp_r), .rsp_g(rsp_g), .rsp_b(rsp_b), .rsp_mismatch(rsp_mismatch),
        .err_sticky(err_sticky), .outstanding(outstanding)
`ifdef HQS_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .mismatch_cnt(mismatch_cnt)
`endif
    );

    always #5 clk_25 = ~clk_25;

    typedef struct {
        logic       owner;
        logic [9:0] x;
        logic [9:0] y;
    } tag_t;

    int   nchk = 0;
    int   nerr = 0;

    // Reference model: outstanding tags as a queue, modes 0=run 1=drain 2=done.
    tag_t mq[$];
    int   m_mode;
    bit   m_last1;
    logic [9:0] e_qx, e_qy, e_rx, e_ry;
    logic [4:0] e_r, e_b;
    logic [5:0] e_g;
    logic e_start, e_rsp0, e_rsp1, e_mm, e_err, e_fd;
    int   e_gc0, e_gc1, e_mmc;
    bit   m_g0, m_g1;
    bit   pipe [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_last1 = 1'b1;
        e_qx = 0; e_qy = 0; e_rx = 0; e_ry = 0; e_r = 0; e_g = 0; e_b = 0;
        e_start = 0; e_rsp0 = 0; e_rsp1 = 0; e_mm = 0; e_err = 0; e_fd = 0;
        e_gc0 = 0; e_gc1 = 0; e_mmc = 0;
    endtask

    task automatic check_outputs();
        chk("start", 32'(start), 32'(e_start));
        chk("query_x", 32'(query_x), 32'(e_qx));
        chk("query_y", 32'(query_y), 32'(e_qy));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rsp0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rsp1));
        chk("rsp_x", 32'(rsp_x), 32'(e_rx));
        chk("rsp_y", 32'(rsp_y), 32'(e_ry));
        chk("rsp_rgb", {16'h0, rsp_r, rsp_g, rsp_b}, {16'h0, e_r, e_g, e_b});
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'(e_mm));
        chk("err_sticky", 32'(err_sticky), 32'(e_err));
        chk("flush_done", 32'(flush_done), 32'(e_fd));
        chk("outstanding", 32'(outstanding), 32'(mq.size()));
`ifdef HQS_STATS_EN
        chk("grant_cnt0", 32'(grant_cnt0), 32'(e_gc0));
        chk("grant_cnt1", 32'(grant_cnt1), 32'(e_gc1));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e_mmc));
`endif
    endtask

    // One clock: drive inputs, check grants, advance model across the edge, check outputs.
    task automatic cycle(input bit v0, input logic [9:0] x0, input logic [9:0] y0,
                         input bit v1, input logic [9:0] x1, input logic [9:0] y1,
                         input bit fl, input bit rd, input logic [9:0] rx, input logic [9:0] ry);
        int   sz;
        bit   pop;
        tag_t hd;
        req0_valid = v0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_x = x1; req1_y = y1;
        flush = fl; ready = rd; return_x = rx; return_y = ry;
        r = 5'($urandom); g = 6'($urandom); b = 5'($urandom);
        sz = mq.size();
        m_g0 = (m_mode == 0) && (sz < DEPTH) && v0 && (!v1 || m_last1);
        m_g1 = (m_mode == 0) && (sz < DEPTH) && v1 && !m_g0;
        #2;
        chk("req0_ready", 32'(req0_ready), 32'(m_g0));
        chk("req1_ready", 32'(req1_ready), 32'(m_g1));
        @(posedge clk_25);
        #1;
        pop = rd && (sz > 0);
        e_rsp0 = 0; e_rsp1 = 0; e_mm = 0;
        if (rd && sz == 0) e_err = 1;
        if (pop) begin
            hd = mq.pop_front();
            e_rsp0 = !hd.owner; e_rsp1 = hd.owner;
            e_rx = hd.x; e_ry = hd.y; e_r = r; e_g = g; e_b = b;
            e_mm = (rx != hd.x) || (ry != hd.y);
            if (e_mm) begin
                e_err = 1;
                if (e_mmc < 65535) e_mmc++;
            end
        end
        e_start = m_g0 || m_g1;
        if (m_g0) begin
            mq.push_back('{1'b0, x0, y0}); e_qx = x0; e_qy = y0; m_last1 = 0;
            if (e_gc0 < 65535) e_gc0++;
        end else if (m_g1) begin
            mq.push_back('{1'b1, x1, y1}); e_qx = x1; e_qy = y1; m_last1 = 1;
            if (e_gc1 < 65535) e_gc1++;
        end
        case (m_mode)
            0: if (fl) m_mode = 1;
            1: if (sz == 0) m_mode = 2;
            default: m_mode = 0;
        endcase
        e_fd = (m_mode == 2);
        check_outputs();
    endtask

    task automatic idle(input bit rd);
        cycle(0, 0, 0, 0, 0, 0, 0, rd, 0, 0);
    endtask

    task automatic drain_all();
        while (mq.size() > 0) cycle(0, 0, 0, 0, 0, 0, 0, 1, mq[0].x, mq[0].y);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; ready = 0; flush = 0;
        #1;
        chk("rst_start", 32'(start), 0);
        chk("rst_rsp", {30'h0, rsp0_valid, rsp1_valid}, 0);
        chk("rst_rsp_xy", {12'h0, rsp_x, rsp_y}, 0);
        chk("rst_err", 32'(err_sticky), 0);
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_ready", {30'h0, req0_ready, req1_ready}, 0);
`ifdef HQS_STATS_EN
        chk("rst_cnts", {grant_cnt0, grant_cnt1 | mismatch_cnt}, 0);
`endif
        model_reset();
        @(posedge clk_25);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        model_reset();
        #1;
        chk("init_flush_done", 32'(flush_done), 0);
        @(posedge clk_25);
        #1;
        rst = 1'b0;
        check_outputs();

        // Both requesters valid for 6 cycles, ready three cycles after each start.
        pipe = '{0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            bit rd;
            rd = pipe[2] && (mq.size() > 0);
            cycle(i < 6, 10'(100 + i), 10'(200 + i), i < 6, 10'(300 + i), 10'(400 + i), 0,
                  rd, rd ? mq[0].x : 10'd0, rd ? mq[0].y : 10'd0);
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e_start;
        end
        chk("t1_empty", 32'(outstanding), 0);

        // req0 alone with ready low fills all DEPTH slots.
        for (int i = 0; i < 10; i++) cycle(1, 10'(i), 10'(i + 1), 0, 0, 0, 0, 0, 0, 0);
        chk("t2_full", 32'(outstanding), 8);
        chk("t2_no_grant", 32'(req0_ready), 0);
        cycle(1, 10'd50, 10'd51, 0, 0, 0, 0, 1, mq[0].x, mq[0].y);
        chk("t2_rsp0", 32'(rsp0_valid), 1);
        chk("t2_out7", 32'(outstanding), 7);
        cycle(1, 10'd52, 10'd53, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_regrant", 32'(start), 1);
        drain_all();

        // Spurious ready with nothing outstanding.
        idle(1);
        chk("t4_no_rsp", {30'h0, rsp0_valid, rsp1_valid}, 0);
        chk("t4_err", 32'(err_sticky), 1);
        chk("t4_out", 32'(outstanding), 0);

        // Reset in the middle of traffic.
        cycle(1, 10'd9, 10'd9, 1, 10'd8, 10'd8, 0, 0, 0, 0);
        cycle(1, 10'd7, 10'd7, 1, 10'd6, 10'd6, 0, 0, 0, 0);
        do_reset();

        // Mismatching return coordinate.
        cycle(1, 10'd5, 10'd7, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 10'd5, 10'd8);
        chk("t3_rsp0", 32'(rsp0_valid), 1);
        chk("t3_rsp_x", 32'(rsp_x), 5);
        chk("t3_rsp_y", 32'(rsp_y), 7);
        chk("t3_mm", 32'(rsp_mismatch), 1);
        chk("t3_err", 32'(err_sticky), 1);
        idle(0);
        chk("t3_err_hold", 32'(err_sticky), 1);

        // Flush with three outstanding.
        for (int i = 0; i < 3; i++) cycle(1, 10'(20 + i), 10'(30 + i), 1, 10'(40 + i), 10'(50 + i), 0, 0, 0, 0);
        cycle(1, 10'd60, 10'd61, 1, 10'd62, 10'd63, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 10'd1, 10'd2, 1, 10'd3, 10'd4, 1, 0, 0, 0);
        chk("t5_no_grant", {30'h0, req0_ready, req1_ready}, 0);
        while (mq.size() > 0) cycle(1, 10'd1, 10'd2, 1, 10'd3, 10'd4, 1, 1, mq[0].x, mq[0].y);
        chk("t5_not_yet", 32'(flush_done), 0);
        idle(0);
        chk("t5_flush_done", 32'(flush_done), 1);
        cycle(1, 10'd11, 10'd12, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 10'd11, 10'd12, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_run_again", 32'(start), 1);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            bit rd, good;
            rd = ($urandom_range(0, 1) == 1);
            good = (mq.size() > 0) && ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 1) == 1, 10'($urandom), 10'($urandom),
                  $urandom_range(0, 1) == 1, 10'($urandom), 10'($urandom),
                  $urandom_range(0, 30) == 0, rd,
                  good ? mq[0].x : 10'($urandom), good ? mq[0].y : 10'($urandom));
        end
        drain_all();

`ifdef HQS_STATS_EN
        // Saturation of grant_cnt1 with immediate returns.
        do_reset();
        for (int i = 0; i < 70001; i++) begin
            bit rd;
            rd = (mq.size() > 0);
            cycle(0, 0, 0, 1, 10'(i), 10'(i >> 10), 0, rd, rd ? mq[0].x : 10'd0, rd ? mq[0].y : 10'd0);
        end
        chk("t6_gc1_sat", 32'(grant_cnt1), 32'h0000FFFF);
        chk("t6_gc0_zero", 32'(grant_cnt0), 0);
`endif
        do_reset();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
